sipo_collector: RTL and testbench
=================================

# sipo_collector

Serial-to-parallel collector that sits directly downstream of the SISO shift register. It samples the serial bit stream (`q_out` of the SISO, qualified by the SISO's output-enable) and assembles `DATA_WIDTH`-bit words. Each completed word is presented on a one-entry valid/ready output buffer. The block reports dropped words, and a flush input discards a partial word.

## Interface
- `DATA_WIDTH`, 4, word width in bits; ≥2.
- `CLOCK_EDGE`, 1, active edge: 1 = rising, 0 = falling. Applies to all state, including the async-reset flops.
- `MSB_FIRST`, 0, bit order: 0 = first received bit lands in bit 0; 1 = first received bit lands in bit `DATA_WIDTH-1`.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `d_in`  in  1  serial data bit.
- `bit_valid_in`  in  1  `d_in` is accepted on the active edge when high.
- `flush_in`  in  1  synchronous discard of the partial word; also clears `overflow_out`.
- `q_out`  out  `DATA_WIDTH`  assembled word; valid only while `valid_out` is high.
- `valid_out`  out  1  output buffer holds a word.
- `ready_in`  in  1  consumer accepts the word on an edge where `valid_out && ready_in`.
- `count_out`  out  `clog2(DATA_WIDTH+1)`  number of bits collected in the current partial word.
- `overflow_out`  out  1  sticky flag: a completed word was dropped.

## Operation
- **Collector shift register `sr`.**
  - LSB-first: `sr <= {d_in, sr[W-1:1]}`.
  - MSB-first: `sr <= {sr[W-2:0], d_in}`.
  - Shifts only on an accepted bit.
- **Bit counter `cnt`.**
  - Runs 0..`W-1` and increments per accepted bit.
  - On the bit that takes it past `W-1`, the word is complete and `cnt` wraps to 0.
  - A complete word means the word formed including the current `d_in`: the next-state value of `sr`.
- **Output FSM, EMPTY/FULL.**
  - EMPTY → FULL when a word completes. `q_out` is loaded with the completed word.
  - FULL → EMPTY on `ready_in` with no completion in the same cycle.
  - FULL with both `ready_in` and a completion: stays FULL and `q_out` is reloaded with the new word. No overflow.
  - FULL with a completion and no `ready_in`: the new word is dropped, `q_out` is unchanged, and `overflow_out` is set.
- **`flush_in`.**
  - Highest priority over bit acceptance: `cnt` → 0 and the bit presented that cycle is discarded.
  - Clears `overflow_out`.
  - Does not touch the output buffer. A handshake in the same cycle still completes.
- `ready_in` while EMPTY is ignored.
- `count_out = cnt`.

## Timing
- **Reset values** (asynchronous on `rst` low): `q_out`=0, `valid_out`=0, `count_out`=0, `overflow_out`=0, `sr`=0, FSM=EMPTY.
- Reset mid-word discards the partial word and any buffered word.
- **Latency:** `valid_out` rises at the same active edge that accepts the last bit of a word, i.e. it is visible in the following cycle.
- **Throughput:** one bit per cycle sustained. A consumer with `ready_in` held high never causes overflow.
- `valid_out` stays high and `q_out` stays stable until the handshake edge. No combinational path from `ready_in` to `valid_out`.
- `overflow_out` rises at the edge of the dropped completion and stays high until `flush_in` or reset.

## Structure
- Shared header `siso_defs.vh` holds:
  - the FSM state encodings `ST_EMPTY`/`ST_FULL`;
  - the clog2 helper function, shared with the SISO and other width-parametric blocks.
- One natural sub-module: `sipo_out_buf`, the one-entry valid/ready holding register with the EMPTY/FULL FSM and overflow detect.
- The top level keeps the collector shift register and bit counter.

## Test plan
- **LSB-first word:** `W`=4, `ready_in`=1, bits 1,0,0,1 on consecutive edges → after the 4th edge `q_out`=4'b1001, `valid_out`=1 for one cycle, `count_out`=0.
- **Back-pressure:** `ready_in`=0, send 4'b1001 then 4'b0110 → `q_out` holds 4'b1001, `overflow_out`=1 after the 8th bit. Then `ready_in`=1 → `valid_out` drops next edge.
- **Simultaneous drain and completion:** FULL with 4'b1001, `ready_in`=1 on the edge that completes 4'b0110 → `q_out`=4'b0110, `valid_out` stays 1, `overflow_out`=0.
- **Flush:** 2 bits (1,1), then `flush_in` with `bit_valid_in`=1, then bits 0,1,1,0 → `q_out`=4'b0110, `count_out` was 0 after the flush. A prior overflow is cleared.
- **Reset mid-operation:** `rst` low after 3 bits while FULL → all outputs 0 immediately, independent of `clk`. The next 4 bits form a clean word.
- **`MSB_FIRST`=1:** bits 1,0,0,1 → `q_out`=4'b1001. Bits 1,1,0,0 → `q_out`=4'b1100 (vs 4'b0011 with `MSB_FIRST`=0).

Source files
------------

// File: rtl/sipo_collector_pkg.sv
// Shared definitions for the serial-to-parallel collector: output buffer
// state encodings and a width helper used by width-parametric blocks.
package sipo_collector_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  // Number of bits needed to represent values 0..value-1
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words, with a
// sticky overflow flag raised when a completed word has nowhere to go.
module sipo_out_buf
  import sipo_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  complete,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  valid,
  output logic                  overflow
);

  buf_state_t            state;
  buf_state_t            state_next;
  logic [DATA_WIDTH-1:0] q_next;
  logic                  overflow_next;

  // Register the buffer state, held word and overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      q        <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      q        <= q_next;
      overflow <= overflow_next;
    end
  end

  // Decide what the buffer holds next; a drain and a completion in the same cycle just swap words
  always_comb begin
    state_next    = state;
    q_next        = q;
    overflow_next = overflow;
    case (state)
      ST_EMPTY: begin
        if (complete) begin
          state_next = ST_FULL;
          q_next     = word;
        end
      end
      ST_FULL: begin
        if (complete && ready) begin
          q_next = word;
        end else if (complete) begin
          overflow_next = 1'b1;
        end else if (ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (flush) begin
      overflow_next = 1'b0;
    end
  end

  assign valid = (state == ST_FULL);

endmodule

// File: rtl/sipo_collector.sv
// Serial-to-parallel collector: shifts accepted serial bits into a word
// and hands each completed word to a one-entry valid/ready buffer.
module sipo_collector
  import sipo_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CLOCK_EDGE = 1,
  parameter int MSB_FIRST  = 0,
  localparam int CW = clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_in,
  input  logic                  bit_valid_in,
  input  logic                  flush_in,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [CW-1:0]         count_out,
  output logic                  overflow_out
);

  logic                  clk_int;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] sr_next;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  accept;
  logic                  complete;

  // Falling-edge operation is obtained by inverting the clock once here
  assign clk_int = (CLOCK_EDGE != 0) ? clk : ~clk;

  // Flush wins over the incoming bit so the discarded bit never enters the word
  assign accept   = bit_valid_in && !flush_in;
  assign complete = accept && (cnt == CW'(DATA_WIDTH - 1));

  // Form the shifted word and the advanced bit count for an accepted bit
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    if (flush_in) begin
      cnt_next = '0;
    end else if (accept) begin
      if (MSB_FIRST != 0) begin
        sr_next = {sr[DATA_WIDTH-2:0], d_in};
      end else begin
        sr_next = {d_in, sr[DATA_WIDTH-1:1]};
      end
      cnt_next = complete ? '0 : cnt + CW'(1);
    end
  end

  // Hold the partial word and its bit count
  always_ff @(posedge clk_int or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      sr  <= sr_next;
      cnt <= cnt_next;
    end
  end

  assign count_out = cnt;

  sipo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk_int),
    .rst      (rst),
    .complete (complete),
    .word     (sr_next),
    .ready    (ready_in),
    .flush    (flush_in),
    .q        (q_out),
    .valid    (valid_out),
    .overflow (overflow_out)
  );

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector: LSB-first and MSB-first instances
// share one stimulus stream; expected values are hand-computed.
module tb_sipo_collector;

  logic       clk;
  logic       rst;
  logic       d_in;
  logic       bit_valid_in;
  logic       flush_in;
  logic       ready_in;
  logic [3:0] q_lsb;
  logic       valid_lsb;
  logic [2:0] count_lsb;
  logic       overflow_lsb;
  logic [3:0] q_msb;
  logic       valid_msb;
  logic [2:0] count_msb;
  logic       overflow_msb;

  int tests_run;
  int tests_failed;

  sipo_collector #(
    .DATA_WIDTH(4),
    .CLOCK_EDGE(1),
    .MSB_FIRST (0)
  ) dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .d_in         (d_in),
    .bit_valid_in (bit_valid_in),
    .flush_in     (flush_in),
    .q_out        (q_lsb),
    .valid_out    (valid_lsb),
    .ready_in     (ready_in),
    .count_out    (count_lsb),
    .overflow_out (overflow_lsb)
  );

  sipo_collector #(
    .DATA_WIDTH(4),
    .CLOCK_EDGE(1),
    .MSB_FIRST (1)
  ) dut_msb (
    .clk          (clk),
    .rst          (rst),
    .d_in         (d_in),
    .bit_valid_in (bit_valid_in),
    .flush_in     (flush_in),
    .q_out        (q_msb),
    .valid_out    (valid_msb),
    .ready_in     (ready_in),
    .count_out    (count_msb),
    .overflow_out (overflow_msb)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one serial bit for the next rising edge, return at the following falling edge
  task automatic apply_stimulus(input logic b);
    d_in = b;
    bit_valid_in = 1'b1;
    @(negedge clk);
    bit_valid_in = 1'b0;
  endtask

  task automatic idle_cycle();
    bit_valid_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    d_in         = 1'b0;
    bit_valid_in = 1'b0;
    flush_in     = 1'b0;
    ready_in     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check_output("reset_q", 32'(q_lsb), 32'h0);
    check_output("reset_valid", 32'(valid_lsb), 32'h0);
    check_output("reset_count", 32'(count_lsb), 32'h0);
    check_output("reset_overflow", 32'(overflow_lsb), 32'h0);

    // LSB-first word 1,0,0,1 with a consumer always ready
    ready_in = 1'b1;
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("count_mid", 32'(count_lsb), 32'h2);
    apply_stimulus(1'b0);
    check_output("no_valid_before_last", 32'(valid_lsb), 32'h0);
    apply_stimulus(1'b1);
    check_output("lsb_word_q", 32'(q_lsb), 32'h9);
    check_output("lsb_word_valid", 32'(valid_lsb), 32'h1);
    check_output("lsb_word_count", 32'(count_lsb), 32'h0);
    check_output("msb_word_q_1001", 32'(q_msb), 32'h9);
    idle_cycle();
    check_output("lsb_word_drained", 32'(valid_lsb), 32'h0);

    // Back-pressure: second word is dropped and overflow sticks
    ready_in = 1'b0;
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("bp_q_held", 32'(q_lsb), 32'h9);
    check_output("bp_valid", 32'(valid_lsb), 32'h1);
    check_output("bp_overflow", 32'(overflow_lsb), 32'h1);
    idle_cycle();
    check_output("bp_overflow_sticky", 32'(overflow_lsb), 32'h1);
    ready_in = 1'b1;
    idle_cycle();
    check_output("bp_drain_valid", 32'(valid_lsb), 32'h0);
    check_output("bp_drain_overflow", 32'(overflow_lsb), 32'h1);

    // Flush discards a partial word and the bit presented with it, and clears overflow
    ready_in = 1'b0;
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    flush_in = 1'b1;
    apply_stimulus(1'b1);
    flush_in = 1'b0;
    check_output("flush_count", 32'(count_lsb), 32'h0);
    check_output("flush_overflow", 32'(overflow_lsb), 32'h0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("flush_word_q", 32'(q_lsb), 32'h6);
    check_output("flush_word_valid", 32'(valid_lsb), 32'h1);
    ready_in = 1'b1;
    idle_cycle();

    // Buffer full with 1001, then drain and complete 0110 on the same edge
    ready_in = 1'b0;
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    ready_in = 1'b1;
    apply_stimulus(1'b0);
    ready_in = 1'b0;
    check_output("swap_q", 32'(q_lsb), 32'h6);
    check_output("swap_valid", 32'(valid_lsb), 32'h1);
    check_output("swap_overflow", 32'(overflow_lsb), 32'h0);
    ready_in = 1'b1;
    idle_cycle();

    // Bit order: 1,1,0,0 gives 0011 LSB-first and 1100 MSB-first
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    check_output("order_lsb_q", 32'(q_lsb), 32'h3);
    check_output("order_msb_q", 32'(q_msb), 32'hC);
    check_output("order_msb_valid", 32'(valid_msb), 32'h1);
    idle_cycle();

    // Reset while full with a partial word pending, away from any clock edge
    ready_in = 1'b0;
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    check_output("pre_reset_valid", 32'(valid_lsb), 32'h1);
    check_output("pre_reset_count", 32'(count_lsb), 32'h3);
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_q", 32'(q_lsb), 32'h0);
    check_output("async_reset_valid", 32'(valid_lsb), 32'h0);
    check_output("async_reset_count", 32'(count_lsb), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    check_output("post_reset_q", 32'(q_lsb), 32'hB);
    check_output("post_reset_valid", 32'(valid_lsb), 32'h1);
    check_output("post_reset_overflow", 32'(overflow_lsb), 32'h0);
    check_output("post_reset_msb_q", 32'(q_msb), 32'hD);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
